// File: rtl/rv32i_single_cycle_processor.sv
// rv32i_single_cycle_processor: single-cycle RV32I core with on-board
// instruction memory (IMEM), data memory (DMEM) and register file (REGFILE).
// Every instruction is fetched, executed and committed in one clock.
// Optional build macro: RV32I_HALT_EN -- when defined, ECALL/EBREAK halt the
// core (PC holds, no writes) until reset; when undefined they are NOPs.

module rv32i_imem #(
    parameter int DEPTH = 256
) (
    input  logic        clk_i,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    input  logic [31:0] addr_i,
    output logic [31:0] rdata_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] cache_mem [0:DEPTH-1];
    logic        unused_bits;

    assign unused_bits = ^{addr_i[31:AW+2], addr_i[1:0],
                           load_addr_i[31:AW+2], load_addr_i[1:0]};

    // Program-load write port; held inactive by the core, so the contents
    // only change when a program image is placed into cache_mem directly.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            cache_mem[load_addr_i[AW+1:2]] <= load_data_i;
        end
    end

    // Word fetch; byte offset bits are ignored and the index wraps.
    assign rdata_o = cache_mem[addr_i[AW+1:2]];
endmodule

module rv32i_dmem #(
    parameter int DEPTH = 256
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   cache_mem [0:DEPTH-1];
    logic [AW-1:0] idx;
    logic          unused_bits;

    assign idx         = addr_i[AW+1:2];
    assign unused_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

    // Byte-lane write on the rising edge.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && be_i[b]) begin
                cache_mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = cache_mem[idx];
endmodule

module rv32i_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] registers [0:31];

    // Single write port; writes to x0 are dropped so registers[0] stays 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            registers[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-edge value, so a same-cycle write is not forwarded.
    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : registers[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : registers[raddr2_i];
endmodule

module rv32i_single_cycle_processor #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] debug_pc,
    output logic [31:0] debug_instruction,
    output logic [31:0] debug_alu_result,
    output logic [31:0] debug_reg_write_data
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_result;
    logic        is_valid, writes_rd, writes_mem, br_taken, stall;
    logic [31:0] wb_data, load_data, dmem_rdata, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        reg_we, dmem_we;

    assign instr  = debug_instruction;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign pc_plus4 = pc_q + 32'd4;

    rv32i_imem #(.DEPTH(IMEM_DEPTH)) IMEM (
        .clk_i       (clk),
        .load_we_i   (1'b0),
        .load_addr_i (32'd0),
        .load_data_i (32'd0),
        .addr_i      (pc_q),
        .rdata_o     (debug_instruction)
    );

    rv32i_regfile REGFILE (
        .clk_i    (clk),
        .rst_ni   (rst),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .we_i     (reg_we),
        .waddr_i  (rd),
        .wdata_i  (wb_data),
        .rdata1_o (rs1_val),
        .rdata2_o (rs2_val)
    );

    rv32i_dmem #(.DEPTH(DMEM_DEPTH)) DMEM (
        .clk_i   (clk),
        .we_i    (dmem_we),
        .be_i    (dmem_be),
        .addr_i  (alu_result),
        .wdata_i (dmem_wdata),
        .rdata_o (dmem_rdata)
    );

    // Legal-encoding decode; anything not recognised commits nothing and
    // falls through to PC+4.
    always_comb begin
        is_valid   = 1'b0;
        writes_rd  = 1'b0;
        writes_mem = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                is_valid  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_JALR: begin
                is_valid  = (funct3 == 3'b000);
                writes_rd = 1'b1;
            end
            OP_BRANCH: is_valid = (funct3 != 3'b010) && (funct3 != 3'b011);
            OP_LOAD: begin
                is_valid  = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                writes_rd = 1'b1;
            end
            OP_STORE: begin
                is_valid   = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
                writes_mem = 1'b1;
            end
            OP_IMM: begin
                writes_rd = 1'b1;
                if (funct3 == 3'b001)      is_valid = (instr[31:25] == 7'b0000000);
                else if (funct3 == 3'b101) is_valid = (instr[31] == 1'b0) && (instr[29:25] == 5'b00000);
                else                       is_valid = 1'b1;
            end
            OP_REG: begin
                writes_rd = 1'b1;
                is_valid  = (instr[31:25] == 7'b0000000) ||
                            ((instr[31:25] == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            default: is_valid = 1'b0;
        endcase
    end

    assign op_b  = (opcode == OP_REG) ? rs2_val : imm_i;
    assign shamt = op_b[4:0];

    // ALU: address generation, integer ops, and rs1-rs2 for branches.
    always_comb begin
        alu_result = 32'd0;
        case (opcode)
            OP_LUI:    alu_result = imm_u;
            OP_AUIPC:  alu_result = pc_q + imm_u;
            OP_JAL:    alu_result = pc_q + imm_j;
            OP_JALR:   alu_result = rs1_val + imm_i;
            OP_BRANCH: alu_result = rs1_val - rs2_val;
            OP_LOAD:   alu_result = rs1_val + imm_i;
            OP_STORE:  alu_result = rs1_val + imm_s;
            OP_IMM, OP_REG: begin
                case (funct3)
                    3'b000: alu_result = ((opcode == OP_REG) && instr[30]) ? rs1_val - op_b : rs1_val + op_b;
                    3'b001: alu_result = rs1_val << shamt;
                    3'b010: alu_result = {31'd0, $signed(rs1_val) < $signed(op_b)};
                    3'b011: alu_result = {31'd0, rs1_val < op_b};
                    3'b100: alu_result = rs1_val ^ op_b;
                    3'b101: alu_result = instr[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
                    3'b110: alu_result = rs1_val | op_b;
                    default: alu_result = rs1_val & op_b;
                endcase
            end
            default: alu_result = 32'd0;
        endcase
    end

    // Branch condition from funct3.
    always_comb begin
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Load extraction: select byte/half by address, then sign/zero extend.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        case (alu_result[1:0])
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    // Store lane enables and replicated write data.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << alu_result[1:0];
                dmem_wdata = {4{rs2_val[7:0]}};
            end
            2'b01: begin
                dmem_be    = alu_result[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{rs2_val[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = rs2_val;
            end
        endcase
    end

    // Writeback source: link address, load data, or ALU result.
    always_comb begin
        case (opcode)
            OP_JAL, OP_JALR: wb_data = pc_plus4;
            OP_LOAD:         wb_data = load_data;
            default:         wb_data = alu_result;
        endcase
    end

`ifdef RV32I_HALT_EN
    logic halted_q, halted_d, is_halt_instr;

    assign is_halt_instr = (instr == 32'h0000_0073) || (instr == 32'h0010_0073);
    assign halted_d      = halted_q | is_halt_instr;
    assign stall         = halted_d;

    // Sticky halt flag; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) halted_q <= 1'b0;
        else      halted_q <= halted_d;
    end
`else
    assign stall = 1'b0;
`endif

    // Memory writes are also gated by reset so an edge during reset stores nothing.
    assign reg_we  = is_valid & writes_rd & ~stall;
    assign dmem_we = is_valid & writes_mem & ~stall & rst;

    // Next-PC selection.
    always_comb begin
        pc_d = pc_plus4;
        if (stall) begin
            pc_d = pc_q;
        end else if (is_valid) begin
            case (opcode)
                OP_JAL:    pc_d = pc_q + imm_j;
                OP_JALR:   pc_d = {alu_result[31:1], 1'b0};
                OP_BRANCH: pc_d = br_taken ? pc_q + imm_b : pc_plus4;
                default:   pc_d = pc_plus4;
            endcase
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

    assign debug_pc             = pc_q;
    assign debug_alu_result     = alu_result;
    assign debug_reg_write_data = wb_data;
endmodule

// File: tb/tb_rv32i_single_cycle_processor.sv
// Directed bench for rv32i_single_cycle_processor: programs are placed into
// IMEM through hierarchy, then architectural state is checked after fixed
// numbers of cycles against hand-computed values.
module tb_rv32i_single_cycle_processor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] debug_pc, debug_instruction, debug_alu_result, debug_reg_write_data;

    int n_cmp = 0;
    int n_err = 0;

    rv32i_single_cycle_processor dut (
        .clk                  (clk),
        .rst                  (rst),
        .debug_pc             (debug_pc),
        .debug_instruction    (debug_instruction),
        .debug_alu_result     (debug_alu_result),
        .debug_reg_write_data (debug_reg_write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin
            dut.IMEM.cache_mem[i] = 32'h0000_0000;
        end
    endtask

    initial begin
        // Program A: arithmetic, memory, branch, ECALL.
        #1 rst = 1'b0;
        clear_mems();
        for (int i = 0; i < 256; i++) dut.DMEM.cache_mem[i] = 32'h0000_0000;
        dut.IMEM.cache_mem[0]  = 32'h0050_0093; // addi x1,x0,5
        dut.IMEM.cache_mem[1]  = 32'h00A0_0113; // addi x2,x0,10
        dut.IMEM.cache_mem[2]  = 32'h0020_81B3; // add  x3,x1,x2
        dut.IMEM.cache_mem[3]  = 32'h4011_0233; // sub  x4,x2,x1
        dut.IMEM.cache_mem[4]  = 32'h0020_F2B3; // and  x5,x1,x2
        dut.IMEM.cache_mem[5]  = 32'h0020_E333; // or   x6,x1,x2
        dut.IMEM.cache_mem[6]  = 32'h0020_C3B3; // xor  x7,x1,x2
        dut.IMEM.cache_mem[7]  = 32'h0030_2023; // sw   x3,0(x0)
        dut.IMEM.cache_mem[8]  = 32'h0000_2403; // lw   x8,0(x0)
        dut.IMEM.cache_mem[9]  = 32'h0140_0493; // addi x9,x0,20
        dut.IMEM.cache_mem[10] = 32'h0010_8463; // beq  x1,x1,+8
        dut.IMEM.cache_mem[11] = 32'h0010_0593; // addi x11,x0,1 (skipped)
        dut.IMEM.cache_mem[12] = 32'h0640_0513; // addi x10,x0,100
        dut.IMEM.cache_mem[13] = 32'h0000_0073; // ecall
        dut.IMEM.cache_mem[14] = 32'h0010_0613; // addi x12,x0,1

        cycles(2);
        check("reset_pc", debug_pc, 32'h0);
        check("reset_instr", debug_instruction, 32'h0050_0093);
        check("reset_imem1", dut.IMEM.cache_mem[1], 32'h00A0_0113);
        for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), dut.REGFILE.registers[i], 32'h0);

        rst = 1'b1;
        cycles(7);
        check("x1_addi", dut.REGFILE.registers[1], 32'h5);
        check("x2_addi", dut.REGFILE.registers[2], 32'hA);
        check("x3_add",  dut.REGFILE.registers[3], 32'hF);
        check("x4_sub",  dut.REGFILE.registers[4], 32'h5);
        check("x5_and",  dut.REGFILE.registers[5], 32'h0);
        check("x6_or",   dut.REGFILE.registers[6], 32'hF);
        check("x7_xor",  dut.REGFILE.registers[7], 32'hF);
        check("pc_1c",   debug_pc, 32'h1C);

        cycles(2);
        check("dmem0_sw", dut.DMEM.cache_mem[0], 32'hF);
        check("x8_lw",    dut.REGFILE.registers[8], 32'hF);
        cycles(1);
        check("x9_addi",   dut.REGFILE.registers[9], 32'h14);
        check("pc_beq",    debug_pc, 32'h28);
        check("beq_instr", debug_instruction, 32'h0010_8463);
        check("beq_alu",   debug_alu_result, 32'h0);
        cycles(1);
        check("pc_beq_taken", debug_pc, 32'h30);
        check("wbdata_addi",  debug_reg_write_data, 32'h64);
        cycles(1);
        check("x10_addi",    dut.REGFILE.registers[10], 32'h64);
        check("x11_skipped", dut.REGFILE.registers[11], 32'h0);
        check("pc_ecall",    debug_pc, 32'h34);

`ifdef RV32I_HALT_EN
        cycles(10);
        check("halt_pc",  debug_pc, 32'h34);
        check("halt_x12", dut.REGFILE.registers[12], 32'h0);
`else
        cycles(1);
        check("ecall_nop_pc", debug_pc, 32'h38);
        check("ecall_nop_x12_pre", dut.REGFILE.registers[12], 32'h0);
        cycles(1);
        check("ecall_nop_x12", dut.REGFILE.registers[12], 32'h1);
`endif

        // Reset mid-program, then Program B: bytes, halves, jumps, x0, misc ops.
        rst = 1'b0;
        cycles(1);
        check("rst2_pc", debug_pc, 32'h0);
        check("rst2_x1", dut.REGFILE.registers[1], 32'h0);
        check("rst2_x10", dut.REGFILE.registers[10], 32'h0);
        clear_mems();
        dut.IMEM.cache_mem[0]  = 32'h0800_0113; // addi x2,x0,0x80
        dut.IMEM.cache_mem[1]  = 32'h0020_00A3; // sb   x2,1(x0)
        dut.IMEM.cache_mem[2]  = 32'h0010_0183; // lb   x3,1(x0)
        dut.IMEM.cache_mem[3]  = 32'h0010_4203; // lbu  x4,1(x0)
        dut.IMEM.cache_mem[4]  = 32'h0010_0293; // addi x5,x0,1
        dut.IMEM.cache_mem[5]  = 32'h0052_9463; // bne  x5,x5,+8
        dut.IMEM.cache_mem[6]  = 32'h0070_0313; // addi x6,x0,7
        dut.IMEM.cache_mem[7]  = 32'h0070_0013; // addi x0,x0,7
        dut.IMEM.cache_mem[8]  = 32'h0310_0393; // addi x7,x0,0x31
        dut.IMEM.cache_mem[9]  = 32'h0003_8467; // jalr x8,0(x7)
        dut.IMEM.cache_mem[10] = 32'h0010_0493; // addi x9,x0,1 (skipped)
        dut.IMEM.cache_mem[11] = 32'h0010_0493; // addi x9,x0,1 (skipped)
        dut.IMEM.cache_mem[12] = 32'h0030_0593; // addi x11,x0,3
        dut.IMEM.cache_mem[13] = 32'h0000_0013; // nop
        dut.IMEM.cache_mem[14] = 32'h0000_0013; // nop
        dut.IMEM.cache_mem[15] = 32'h0000_0013; // nop
        dut.IMEM.cache_mem[16] = 32'h0100_00EF; // jal  x1,+16
        dut.IMEM.cache_mem[17] = 32'h0010_0613; // addi x12,x0,1 (skipped)
        dut.IMEM.cache_mem[18] = 32'h0010_0613;
        dut.IMEM.cache_mem[19] = 32'h0010_0613;
        dut.IMEM.cache_mem[20] = 32'h0050_0693; // addi x13,x0,5
        dut.IMEM.cache_mem[21] = 32'h1234_5737; // lui  x14,0x12345
        dut.IMEM.cache_mem[22] = 32'h0000_1797; // auipc x15,1
        dut.IMEM.cache_mem[23] = 32'h4041_D813; // srai x16,x3,4
        dut.IMEM.cache_mem[24] = 32'h0032_B8B3; // sltu x17,x5,x3
        dut.IMEM.cache_mem[25] = 32'h0051_A933; // slt  x18,x3,x5
        dut.IMEM.cache_mem[26] = 32'h0020_1123; // sh   x2,2(x0)
        dut.IMEM.cache_mem[27] = 32'h0020_1983; // lh   x19,2(x0)
        cycles(1);
        rst = 1'b1;

        cycles(4);
        check("x2_0x80",   dut.REGFILE.registers[2], 32'h80);
        check("dmem0_sb",  dut.DMEM.cache_mem[0], 32'h0000_800F);
        check("x3_lb",     dut.REGFILE.registers[3], 32'hFFFF_FF80);
        check("x4_lbu",    dut.REGFILE.registers[4], 32'h80);
        cycles(2);
        check("pc_bne_fallthru", debug_pc, 32'h18);
        cycles(1);
        check("x6_after_bne", dut.REGFILE.registers[6], 32'h7);
        check("x0_wbdata",    debug_reg_write_data, 32'h7);
        cycles(1);
        check("x0_stays_0", dut.REGFILE.registers[0], 32'h0);
        cycles(2);
        check("pc_jalr_lsb", debug_pc, 32'h30);
        check("x8_jalr_link", dut.REGFILE.registers[8], 32'h28);
        cycles(4);
        check("pc_jal_site", debug_pc, 32'h40);
        check("x9_skipped", dut.REGFILE.registers[9], 32'h0);
        check("x11_addi", dut.REGFILE.registers[11], 32'h3);
        cycles(1);
        check("pc_jal", debug_pc, 32'h50);
        check("x1_jal_link", dut.REGFILE.registers[1], 32'h44);
        cycles(8);
        check("x12_skipped", dut.REGFILE.registers[12], 32'h0);
        check("x13_addi", dut.REGFILE.registers[13], 32'h5);
        check("x14_lui", dut.REGFILE.registers[14], 32'h1234_5000);
        check("x15_auipc", dut.REGFILE.registers[15], 32'h0000_1058);
        check("x16_srai", dut.REGFILE.registers[16], 32'hFFFF_FFF8);
        check("x17_sltu", dut.REGFILE.registers[17], 32'h1);
        check("x18_slt", dut.REGFILE.registers[18], 32'h1);
        check("dmem0_sh", dut.DMEM.cache_mem[0], 32'h0080_800F);
        check("x19_lh", dut.REGFILE.registers[19], 32'h80);
        check("pc_end", debug_pc, 32'h70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
